// File: rtl/bp_pkg.sv
// Shared types and constants for the output-layer backprop scheduler.
// The datapath widths describe the output_backprop instance this block drives.
package bp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_DONE   = 3'd5
    } bp_state_t;

    localparam int W_WIDTH  = 8;
    localparam int PASS_W   = 8;

    localparam int TARGET_W = 4;
    localparam int FINAL_W  = 19;
    localparam int HIDDEN_W = 10;

endpackage

// File: rtl/backprop_scheduler.sv
// Walks every hidden-to-output weight through the shared output_backprop datapath
// (read, update, write back) and runs the zero-weight sweep on request.
module backprop_scheduler
    import bp_pkg::*;
#(
    parameter int N_HIDDEN = 4,
    parameter int W_WIDTH  = bp_pkg::W_WIDTH,
    parameter int IDX_W    = $clog2(N_HIDDEN)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [PASS_W-1:0]  passes_o,
    output logic [IDX_W-1:0]   raddr_o,
    input  logic [W_WIDTH-1:0] rdata_i,
    output logic               we_o,
    output logic [IDX_W-1:0]   waddr_o,
    output logic [W_WIDTH-1:0] wdata_o,
    output logic [IDX_W-1:0]   hsel_o,
    output logic               dp_en_o,
    output logic [W_WIDTH-1:0] dp_w_o,
    output logic               dp_zero_o,
    input  logic [W_WIDTH-1:0] dp_w_i,
    input  logic               dp_ready_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

    bp_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              last_idx;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            passes_q <= passes_d;
        end
    end

    assign last_idx = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        passes_d  = passes_q;
        we_o      = 1'b0;
        wdata_o   = '0;
        dp_en_o   = 1'b0;
        dp_w_o    = '0;
        dp_zero_o = 1'b0;
        done_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (clear_i) begin
                    state_d = ST_CLEAR;
                end else if (start_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // Read data stays valid while stalled: raddr_o keeps presenting idx.
                dp_en_o = 1'b1;
                dp_w_o  = rdata_i;
                if (dp_ready_i) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we_o    = 1'b1;
                wdata_o = dp_w_i;
                if (last_idx) begin
                    state_d  = ST_DONE;
                    passes_d = passes_q + PASS_W'(1);
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_CLEAR: begin
                dp_zero_o = 1'b1;
                we_o      = 1'b1;
                if (last_idx) begin
                    state_d  = ST_DONE;
                    passes_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign passes_o = passes_q;
    assign raddr_o  = idx_q;
    assign waddr_o  = idx_q;
    assign hsel_o   = idx_q;

endmodule
